// File: rtl/alu_pkg.sv
// Shared widths, select encodings and response record for the ALU sequencer.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  typedef enum logic {
    SEL_ARITH = 1'b0,
    SEL_LOGIC = 1'b1
  } sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              overflow;
  } rsp_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Response FIFO for alu_sequencer: DEPTH entries, head reads zero while empty.
module alu_seq_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  rsp_t          push_data,
  output rsp_t          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rsp_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues requests to an external ALU and buffers its results in order.
// Optional macro ALU_SEQ_CHAIN_EN adds req_chain (reuse previous result as arg1).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_select,
  input  logic [OP_W-1:0]   req_opcode,
  input  logic [DATA_W-1:0] req_arg1,
  input  logic [DATA_W-1:0] req_arg2,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              req_chain,
`endif
  output logic              alu_select,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_arg1,
  output logic [DATA_W-1:0] alu_arg2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_overflow
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic              accept;
  logic              pop;
  logic              exec_pending;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW:0]       occupancy;
  logic [DATA_W-1:0] arg1_in;
  rsp_t              push_data;
  rsp_t              head;

  assign pop     = rsp_valid & rsp_ready;
  assign accept  = req_valid & req_ready;

  // Slots already committed (buffered + executing), less the one leaving this cycle.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, exec_pending} - {{CW{1'b0}}, pop};
  assign req_ready = occupancy < (CW + 1)'(RSP_DEPTH);

`ifdef ALU_SEQ_CHAIN_EN
  logic [DATA_W-1:0] last_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            last_result <= '0;
    else if (exec_pending) last_result <= alu_result;
  end

  // An operation still executing has not reached last_result yet, so forward it.
  assign arg1_in = req_chain ? (exec_pending ? alu_result : last_result) : req_arg1;
`else
  assign arg1_in = req_arg1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_select   <= 1'b0;
      alu_opcode   <= '0;
      alu_arg1     <= '0;
      alu_arg2     <= '0;
      exec_pending <= 1'b0;
    end else begin
      exec_pending <= accept;
      if (accept) begin
        alu_select <= req_select;
        alu_opcode <= req_opcode;
        alu_arg1   <= arg1_in;
        alu_arg2   <= req_arg2;
      end
    end
  end

  assign push_data = '{result: alu_result, carry: alu_carry, overflow: alu_overflow};

  alu_seq_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (exec_pending),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid    = ~fifo_empty;
  assign rsp_result   = head.result;
  assign rsp_carry    = head.carry;
  assign rsp_overflow = head.overflow;

  no_overflow_push: assert property (@(posedge clk) disable iff (!rst_n)
    !(exec_pending && fifo_full && !pop));

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to its alu_* port.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_select;
  logic [OP_W-1:0]   req_opcode;
  logic [DATA_W-1:0] req_arg1;
  logic [DATA_W-1:0] req_arg2;
  logic              req_chain;
  logic              alu_select;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_arg1;
  logic [DATA_W-1:0] alu_arg2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_overflow;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_overflow;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.RSP_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_select   (req_select),
    .req_opcode   (req_opcode),
    .req_arg1     (req_arg1),
    .req_arg2     (req_arg2),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain    (req_chain),
`endif
    .alu_select   (alu_select),
    .alu_opcode   (alu_opcode),
    .alu_arg1     (alu_arg1),
    .alu_arg2     (alu_arg2),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow)
  );

  // External ALU: arith {add, sub(borrow)}, logic {and, or, xor, not}.
  always_comb begin
    logic [DATA_W:0] wide;
    wide         = '0;
    alu_result   = alu_arg1;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    if (alu_select == SEL_ARITH) begin
      if (alu_opcode == 3'd0) begin
        wide         = {1'b0, alu_arg1} + {1'b0, alu_arg2};
        alu_result   = wide[DATA_W-1:0];
        alu_carry    = wide[DATA_W];
        alu_overflow = (alu_arg1[15] == alu_arg2[15]) && (wide[15] != alu_arg1[15]);
      end else if (alu_opcode == 3'd1) begin
        wide         = {1'b0, alu_arg1} - {1'b0, alu_arg2};
        alu_result   = wide[DATA_W-1:0];
        alu_carry    = wide[DATA_W];
        alu_overflow = (alu_arg1[15] != alu_arg2[15]) && (wide[15] != alu_arg1[15]);
      end
    end else begin
      case (alu_opcode)
        3'd0:    alu_result = alu_arg1 & alu_arg2;
        3'd1:    alu_result = alu_arg1 | alu_arg2;
        3'd2:    alu_result = alu_arg1 ^ alu_arg2;
        3'd3:    alu_result = ~alu_arg1;
        default: alu_result = alu_arg1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  logic              v_sel [8];
  logic [OP_W-1:0]   v_op  [8];
  logic [DATA_W-1:0] v_a   [8];
  logic [DATA_W-1:0] v_b   [8];
  logic [DATA_W-1:0] e_res [8];
  logic              e_c   [8];
  logic              e_v   [8];

  task automatic drive(input int unsigned k);
    req_valid  = 1'b1;
    req_select = v_sel[k];
    req_opcode = v_op[k];
    req_arg1   = v_a[k];
    req_arg2   = v_b[k];
  endtask

  task automatic check_head(input string tag, input int unsigned k);
    check({tag, ".valid"}, {15'd0, rsp_valid}, 16'd1);
    check({tag, ".result"}, rsp_result, e_res[k]);
    check({tag, ".carry"}, {15'd0, rsp_carry}, {15'd0, e_c[k]});
    check({tag, ".ovf"}, {15'd0, rsp_overflow}, {15'd0, e_v[k]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Hand-computed vectors: {sel, op, a, b} -> {result, carry, overflow}
    v_sel[0] = 0; v_op[0] = 0; v_a[0] = 16'h1234; v_b[0] = 16'h1111; e_res[0] = 16'h2345; e_c[0] = 0; e_v[0] = 0;
    v_sel[1] = 0; v_op[1] = 0; v_a[1] = 16'h7FFF; v_b[1] = 16'h0001; e_res[1] = 16'h8000; e_c[1] = 0; e_v[1] = 1;
    v_sel[2] = 0; v_op[2] = 1; v_a[2] = 16'h0005; v_b[2] = 16'h0007; e_res[2] = 16'hFFFE; e_c[2] = 1; e_v[2] = 0;
    v_sel[3] = 0; v_op[3] = 1; v_a[3] = 16'h8000; v_b[3] = 16'h0001; e_res[3] = 16'h7FFF; e_c[3] = 0; e_v[3] = 1;
    v_sel[4] = 1; v_op[4] = 0; v_a[4] = 16'hF0F0; v_b[4] = 16'h0FF0; e_res[4] = 16'h00F0; e_c[4] = 0; e_v[4] = 0;
    v_sel[5] = 1; v_op[5] = 1; v_a[5] = 16'hF000; v_b[5] = 16'h000F; e_res[5] = 16'hF00F; e_c[5] = 0; e_v[5] = 0;
    v_sel[6] = 1; v_op[6] = 2; v_a[6] = 16'hAAAA; v_b[6] = 16'hFFFF; e_res[6] = 16'h5555; e_c[6] = 0; e_v[6] = 0;
    v_sel[7] = 1; v_op[7] = 3; v_a[7] = 16'h1234; v_b[7] = 16'h0000; e_res[7] = 16'hEDCB; e_c[7] = 0; e_v[7] = 0;

    rst_n = 1'b0; req_valid = 1'b0; req_select = 1'b0; req_opcode = '0;
    req_arg1 = '0; req_arg2 = '0; req_chain = 1'b0; rsp_ready = 1'b1;

    // Reset state
    #2;
    check("rst.req_ready", {15'd0, req_ready}, 16'd1);
    check("rst.rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst.alu_arg1", alu_arg1, 16'h0000);
    check("rst.rsp_result", rsp_result, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single op: FFFF + 0001 -> 0000, carry 1, overflow 0
    req_valid = 1'b1; req_select = 1'b0; req_opcode = 3'd0;
    req_arg1 = 16'hFFFF; req_arg2 = 16'h0001;
    #1 check("single.ready", {15'd0, req_ready}, 16'd1);
    @(negedge clk); req_valid = 1'b0;
    #1;
    check("single.alu_arg1", alu_arg1, 16'hFFFF);
    check("single.alu_arg2", alu_arg2, 16'h0001);
    check("single.early_valid", {15'd0, rsp_valid}, 16'd0);
    @(negedge clk); #1;
    check("single.valid", {15'd0, rsp_valid}, 16'd1);
    check("single.result", rsp_result, 16'h0000);
    check("single.carry", {15'd0, rsp_carry}, 16'd1);
    check("single.ovf", {15'd0, rsp_overflow}, 16'd0);
    @(negedge clk); #1;
    check("single.drained", {15'd0, rsp_valid}, 16'd0);
    check("single.zero_head", rsp_result, 16'h0000);

    // Back-to-back: 8 accepts, responses two negedges later on consecutive cycles
    for (int unsigned j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j < 8) drive(j); else req_valid = 1'b0;
      #1;
      if (j < 8) check($sformatf("b2b.ready%0d", j), {15'd0, req_ready}, 16'd1);
      if (j >= 2) check_head($sformatf("b2b.rsp%0d", j - 2), j - 2);
    end
    @(negedge clk); #1;
    check("b2b.drained", {15'd0, rsp_valid}, 16'd0);

    // Backpressure with depth 2
    rsp_ready = 1'b0;
    @(negedge clk); drive(0); #1 check("bp.ready0", {15'd0, req_ready}, 16'd1);
    @(negedge clk); drive(1); #1 check("bp.ready1", {15'd0, req_ready}, 16'd1);
    @(negedge clk); drive(2); #1 check("bp.ready2", {15'd0, req_ready}, 16'd0);
    @(negedge clk); #1;
    check("bp.still_blocked", {15'd0, req_ready}, 16'd0);
    check_head("bp.hold", 0);
    rsp_ready = 1'b1;
    #1 check("bp.release_ready", {15'd0, req_ready}, 16'd1);
    @(negedge clk); drive(3); #1;
    check("bp.ready3", {15'd0, req_ready}, 16'd1);
    check_head("bp.rsp1", 1);
    @(negedge clk); req_valid = 1'b0; #1 check_head("bp.rsp2", 2);
    @(negedge clk); #1 check_head("bp.rsp3", 3);
    @(negedge clk); #1 check("bp.drained", {15'd0, rsp_valid}, 16'd0);

    // Reset with one buffered response and one operation executing
    rsp_ready = 1'b0;
    @(negedge clk); drive(4);
    @(negedge clk); drive(5);
    @(negedge clk); req_valid = 1'b0; #1;
    check("rstmid.pre_valid", {15'd0, rsp_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.valid", {15'd0, rsp_valid}, 16'd0);
    check("rstmid.alu_arg1", alu_arg1, 16'h0000);
    check("rstmid.alu_op", {13'd0, alu_opcode}, 16'h0000);
    check("rstmid.alu_sel", {15'd0, alu_select}, 16'h0000);
    check("rstmid.ready", {15'd0, req_ready}, 16'd1);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    for (int unsigned j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      check($sformatf("rstmid.no_stale%0d", j), {15'd0, rsp_valid}, 16'd0);
    end

`ifdef ALU_SEQ_CHAIN_EN
    // Chain: A = 3 + 4 = 7, B forwards 7 as arg1 -> 7 + 1 = 8, C reads last_result 8
    @(negedge clk);
    req_valid = 1'b1; req_select = 1'b0; req_opcode = 3'd0;
    req_arg1 = 16'h0003; req_arg2 = 16'h0004; req_chain = 1'b0;
    @(negedge clk);
    req_arg1 = 16'h9999; req_arg2 = 16'h0001; req_chain = 1'b1;
    @(negedge clk); req_valid = 1'b0; req_chain = 1'b0; #1;
    check("chain.fwd_arg1", alu_arg1, 16'h0007);
    check("chain.rspA", rsp_result, 16'h0007);
    @(negedge clk); #1 check("chain.rspB", rsp_result, 16'h0008);
    @(negedge clk);
    req_valid = 1'b1; req_arg1 = 16'h5555; req_arg2 = 16'h0002; req_chain = 1'b1;
    @(negedge clk); req_valid = 1'b0; req_chain = 1'b0; #1;
    check("chain.last_arg1", alu_arg1, 16'h0008);
    @(negedge clk); #1 check("chain.rspC", rsp_result, 16'h000A);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
